radix_op_router: RTL and testbench

- Multi-radix arithmetic execution block. Accepts one operation per start and executes it on one of three modelled engines: base-2, base-10 or base-12.
- The engine is either forced by cond_sel or chosen automatically as the opcode's native engine.
- Each engine/op-family pair has its own latency, so a benchmark controller can compare total cycle counts per routing condition.

---
 rtl/radix_op_router.sv | 148 ++++++++++++++
 tb/tb_radix_op_router.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/radix_op_router.sv
// Routes one arithmetic op to a base-2/10/12 engine model and reports it after the engine/family latency.
// Single outstanding op: start is taken only while not busy; done pulses one cycle with the result.
module radix_op_router #(
  parameter int unsigned B2_LAT_BIN  = 1,
  parameter int unsigned B2_LAT_DEC  = 8,
  parameter int unsigned B2_LAT_DUO  = 6,
  parameter int unsigned B10_LAT_DEC = 1,
  parameter int unsigned B10_LAT_BIN = 6,
  parameter int unsigned B10_LAT_DUO = 6,
  parameter int unsigned B12_LAT_DUO = 1,
  parameter int unsigned B12_LAT_BIN = 6,
  parameter int unsigned B12_LAT_DEC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cond_sel,
  input  logic [3:0]  opcode,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] FAM_BIN = 2'd0;
  localparam logic [1:0] FAM_DEC = 2'd1;
  localparam logic [1:0] FAM_DUO = 2'd2;
  localparam logic [1:0] FAM_BAD = 2'd3;

  // Zero latency still needs one cycle; oversized values saturate to the counter range.
  function automatic logic [15:0] clamp_lat(input int unsigned v);
    if (v == 0) return 16'd1;
    if (v > 32'd65535) return 16'hFFFF;
    return v[15:0];
  endfunction

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [31:0] res_q, res_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] lat_q, lat_d;

  logic [1:0]  fam;
  logic [1:0]  eng;
  logic [15:0] lat_sel;
  logic [31:0] res_calc;

  always_comb begin
    fam = FAM_BAD;
    if (opcode <= 4'd2)      fam = FAM_BIN;
    else if (opcode <= 4'd5) fam = FAM_DEC;
    else if (opcode <= 4'd8) fam = FAM_DUO;
    eng = (cond_sel == 2'd3) ? fam : cond_sel;
  end

  always_comb begin
    lat_sel = 16'd1;
    if (fam != FAM_BAD) begin
      case (eng)
        2'd0:    lat_sel = (fam == FAM_BIN) ? clamp_lat(B2_LAT_BIN)
                         : (fam == FAM_DEC) ? clamp_lat(B2_LAT_DEC) : clamp_lat(B2_LAT_DUO);
        2'd1:    lat_sel = (fam == FAM_BIN) ? clamp_lat(B10_LAT_BIN)
                         : (fam == FAM_DEC) ? clamp_lat(B10_LAT_DEC) : clamp_lat(B10_LAT_DUO);
        default: lat_sel = (fam == FAM_BIN) ? clamp_lat(B12_LAT_BIN)
                         : (fam == FAM_DEC) ? clamp_lat(B12_LAT_DEC) : clamp_lat(B12_LAT_DUO);
      endcase
    end
  end

  // Every engine yields the same numeric answer; only the latency differs.
  always_comb begin
    case (opcode)
      4'd0, 4'd3, 4'd6: res_calc = 32'(op_a) + 32'(op_b);
      4'd1, 4'd4, 4'd7: res_calc = 32'(op_a) - 32'(op_b);
      4'd2:             res_calc = 32'(op_a) * 32'(op_b);
      4'd5:             res_calc = 32'(op_a) * 32'd10;
      4'd8:             res_calc = 32'(op_a) * 32'd3;
      default:          res_calc = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          cnt_d   = 16'd1;
          lat_d   = lat_sel;
          res_d   = res_calc;
        end
      end
      ST_RUN: begin
        if (cnt_q >= lat_q) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = res_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      res_q    <= 32'd0;
      cnt_q    <= 16'd0;
      lat_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_radix_op_router.sv
// Scoreboard bench for radix_op_router: expectations queued at start, checked when done pulses.
module tb_radix_op_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  cond_sel;
  logic [3:0]  opcode;
  logic [15:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  radix_op_router dut (
    .clk(clk), .rst(rst_n), .start(start), .cond_sel(cond_sel), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int          tbl_a [9] = '{1000, 3000, 73, 2345, 9000, 1234, 1023, 5000, 4095};
  int          tbl_b [9] = '{1234, 1234, 91, 6789, 1234, 55, 2047, 1337, 777};
  logic [31:0] tbl_r [9] = '{2234, 1766, 6643, 9134, 7766, 12340, 3070, 3663, 12285};
  // Indexed [cond_sel][family]; cond_sel 3 always lands on the native one-cycle engine.
  int          lat_tbl [4][3] = '{'{1, 8, 6}, '{6, 1, 6}, '{6, 8, 1}, '{1, 1, 1}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [1:0] cs, input logic [3:0] opc, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] r, input int l,
                        input int inj_at, output int lat_meas);
    exp_t e;
    int   n;
    bit   busy_ok;
    e.tag = $sformatf("c%0d_op%0d", cs, opc);
    e.res = r;
    e.lat = l;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; cond_sel = cs; opcode = opc; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    cond_sel = 2'($urandom); opcode = 4'($urandom);
    op_a = 16'($urandom); op_b = 16'($urandom);
    n = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 64) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
      start = (n == inj_at);
    end
    start = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_done"}, 32'(done), 32'd1);
    check({e.tag, "_lat"}, 32'(n), 32'(e.lat));
    check({e.tag, "_res"}, result, e.res);
    check({e.tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    check({e.tag, "_busy_done"}, 32'(busy), 32'd0);
    lat_meas = n;
    @(negedge clk);
    check({e.tag, "_pulse"}, 32'(done), 32'd0);
    check({e.tag, "_hold"}, result, e.res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, sum, extra;
    rst_n = 1'b0; start = 1'b0; cond_sel = 2'd0; opcode = 4'd0; op_a = 16'd0; op_b = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);

    run_op(2'd0, 4'd0, 16'd1000, 16'd1234, 32'd2234, 1, -1, lat);
    run_op(2'd1, 4'd0, 16'd1000, 16'd1234, 32'd2234, 6, -1, lat);
    run_op(2'd2, 4'd3, 16'd2345, 16'd6789, 32'd9134, 8, -1, lat);

    for (int c = 0; c < 4; c++) begin
      sum = 0;
      for (int i = 0; i < 9; i++) begin
        run_op(2'(c), 4'(i), 16'(tbl_a[i]), 16'(tbl_b[i]), tbl_r[i], lat_tbl[c][i / 3], -1, lat);
        sum += lat;
      end
      check($sformatf("sum_c%0d", c), 32'(sum), (c == 1) ? 32'd39 : (c == 3) ? 32'd9 : 32'd45);
    end

    run_op(2'd3, 4'd1, 16'd1000, 16'd1234, 32'hFFFF_FF16, 1, -1, lat);
    run_op(2'd1, 4'd12, 16'd77, 16'd88, 32'd0, 1, -1, lat);

    // Second start lands mid-operation and must vanish.
    run_op(2'd1, 4'd0, 16'd5, 16'd6, 32'd11, 6, 2, lat);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("ignored_start_extra_done", 32'(extra), 32'd0);

    // Abort a long op with reset at its third cycle.
    @(negedge clk);
    start = 1'b1; cond_sel = 2'd2; opcode = 4'd3; op_a = 16'd100; op_b = 16'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    run_op(2'd0, 4'd2, 16'd300, 16'd400, 32'd120000, 1, -1, lat);
    run_op(2'd0, 4'd8, 16'd65535, 16'd1, 32'd196605, 6, -1, lat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
